// File: rtl/test_mon_pkg.sv
// rtl/test_mon_pkg.sv - shared types and constants for the test monitor
package test_mon_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ACTIVE,
        PASSED,
        FAILED,
        STALLED
    } hart_status_e;

    localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/hart_monitor.sv
// rtl/hart_monitor.sv - per-hart tohost decode, passed flag and idle watchdog
// Idle watchdog built only when TEST_MON_STALL_DETECT_EN is defined.
module hart_monitor
    import test_mon_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              CNT_W       = 32,
    parameter int              STALL_LIMIT = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              retire_valid,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output hart_status_e      status,
    output logic [DATA_W-1:0] fail_code
);

    logic passed_q, passed_d;
    logic tohost_hit, pass_hit, fail_hit, stall_hit;

    // A hart that has already passed no longer influences the verdict.
    always_comb begin
        tohost_hit = run && !passed_q && st_valid && (st_addr == TOHOST_ADDR);
        pass_hit   = tohost_hit && (st_data == DATA_W'(TOHOST_PASS));
        fail_hit   = tohost_hit && st_data[0] && !pass_hit;
        passed_d   = passed_q | pass_hit;
    end

`ifdef TEST_MON_STALL_DETECT_EN
    logic [CNT_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (run) begin
            if (retire_valid) begin
                idle_d = '0;
            end else if (idle_q != {CNT_W{1'b1}}) begin
                idle_d = idle_q + 1'b1;
            end
        end
        stall_hit = run && !passed_q && (idle_q >= CNT_W'(STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    localparam int unused_stall_cfg = STALL_LIMIT + CNT_W;
    logic unused_retire;
    assign unused_retire = retire_valid;
    assign stall_hit     = 1'b0;
`endif

    always_comb begin
        status = ACTIVE;
        if (fail_hit) begin
            status = FAILED;
        end else if (stall_hit) begin
            status = STALLED;
        end else if (passed_d) begin
            status = PASSED;
        end
        fail_code = fail_hit ? (st_data >> 1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            passed_q <= 1'b0;
        end else begin
            passed_q <= passed_d;
        end
    end

endmodule

// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - reset sequencer and sticky pass/fail/timeout/stall verdict
// Stall detection enabled by defining TEST_MON_STALL_DETECT_EN.
module test_monitor
    import test_mon_pkg::*;
#(
    parameter int              NUM_HARTS      = 1,
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter int              CNT_W          = 32,
    parameter int              RESET_CYCLES   = 2,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              STALL_LIMIT    = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000)
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          core_reset,
    input  logic [NUM_HARTS-1:0]          retire_valid,
    input  logic [NUM_HARTS-1:0]          st_valid,
    input  logic [NUM_HARTS*ADDR_W-1:0]   st_addr,
    input  logic [NUM_HARTS*DATA_W-1:0]   st_data,
    output logic                          done,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout,
    output logic                          stall,
    output logic [DATA_W-1:0]             fail_code,
    output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0] fail_hart,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic                pass_q, pass_d, fail_q, fail_d;
    logic                timeout_q, timeout_d, stall_q, stall_d;
    logic [DATA_W-1:0]   code_q, code_d;
    logic [HART_W-1:0]   hart_q, hart_d;

    logic                run;
    hart_status_e        status    [NUM_HARTS];
    logic [DATA_W-1:0]   hart_code [NUM_HARTS];

    assign run = (state_q == RUN);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        hart_monitor #(
            .ADDR_W      (ADDR_W),
            .DATA_W      (DATA_W),
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT),
            .TOHOST_ADDR (TOHOST_ADDR)
        ) u_hart (
            .clk          (clk),
            .reset        (reset),
            .run          (run),
            .retire_valid (retire_valid[h]),
            .st_valid     (st_valid[h]),
            .st_addr      (st_addr[h*ADDR_W +: ADDR_W]),
            .st_data      (st_data[h*DATA_W +: DATA_W]),
            .status       (status[h]),
            .fail_code    (hart_code[h])
        );
    end

    logic              fail_any, stall_any, pass_all, timeout_hit;
    logic [HART_W-1:0] fail_idx, stall_idx;
    logic [DATA_W-1:0] sel_code;

    // Scan downwards so the lowest-index hart is the one left standing.
    always_comb begin
        fail_any  = 1'b0;
        stall_any = 1'b0;
        pass_all  = 1'b1;
        fail_idx  = '0;
        stall_idx = '0;
        sel_code  = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (status[h] == FAILED) begin
                fail_any = 1'b1;
                fail_idx = HART_W'(h);
                sel_code = hart_code[h];
            end
            if (status[h] == STALLED) begin
                stall_any = 1'b1;
                stall_idx = HART_W'(h);
            end
            if (status[h] != PASSED) begin
                pass_all = 1'b0;
            end
        end
        timeout_hit = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        stall_d   = stall_q;
        code_d    = code_q;
        hart_d    = hart_q;
        case (state_q)
            HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (cycle_q != {CNT_W{1'b1}}) begin
                    cycle_d = cycle_q + 1'b1;
                end
                // fail > stall > pass > timeout
                if (fail_any) begin
                    fail_d  = 1'b1;
                    code_d  = sel_code;
                    hart_d  = fail_idx;
                    state_d = DONE;
                end else if (stall_any) begin
                    stall_d = 1'b1;
                    hart_d  = stall_idx;
                    state_d = DONE;
                end else if (pass_all) begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            cycle_q   <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            stall_q   <= 1'b0;
            code_q    <= '0;
            hart_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            code_q    <= code_d;
            hart_q    <= hart_d;
        end
    end

    assign core_reset  = (state_q != RUN);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign stall       = stall_q;
    assign fail_code   = code_q;
    assign fail_hart   = hart_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - directed and random checks of test_monitor against a reference model
module tb_test_monitor;

    localparam int NH    = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int RC    = 3;
    localparam int TO    = 50;
    localparam int SL    = 8;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_reset;
    logic [NH-1:0]   retire_valid;
    logic [NH-1:0]   st_valid;
    logic [NH*AW-1:0] st_addr;
    logic [NH*DW-1:0] st_data;
    logic            done, pass, fail, timeout, stall;
    logic [DW-1:0]   fail_code;
    logic [0:0]      fail_hart;
    logic [CW-1:0]   cycle_count;

    test_monitor #(
        .NUM_HARTS(NH), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
        .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .STALL_LIMIT(SL), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .reset(reset), .core_reset(core_reset),
        .retire_valid(retire_valid), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .stall(stall),
        .fail_code(fail_code), .fail_hart(fail_hart), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase flags, run-cycle index and per-hart history.
    int          m_hold;
    bit          m_run, m_done, m_pass, m_fail, m_timeout, m_stall;
    int          m_t;
    logic [31:0] m_code;
    int          m_hart;
    bit          m_passed [NH];
    int          m_last   [NH];

    typedef struct {
        int          t;
        int          h;
        logic [31:0] a;
        logic [31:0] d;
    } st_ev_t;
    st_ev_t sched[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_hold = RC; m_run = 0; m_done = 0;
            m_pass = 0; m_fail = 0; m_timeout = 0; m_stall = 0;
            m_t = 0; m_code = 0; m_hart = 0;
            for (int h = 0; h < NH; h++) begin
                m_passed[h] = 0;
                m_last[h]   = -1;
            end
        end else if (m_done) begin
        end else if (!m_run) begin
            m_hold--;
            if (m_hold == 0) m_run = 1;
        end else begin
            int          fail_h = -1;
            int          stall_h = -1;
            bit          all = 1;
            logic [31:0] fcode = 0;
            for (int h = 0; h < NH; h++) begin
                logic [31:0] d = st_data[h*DW +: DW];
                bit hit = st_valid[h] && (st_addr[h*AW +: AW] == TOHOST) && !m_passed[h];
                if (hit && d[0] && d != 1 && fail_h < 0) begin
                    fail_h = h;
                    fcode  = d >> 1;
                end
`ifdef TEST_MON_STALL_DETECT_EN
                if (!m_passed[h] && (m_t - m_last[h] - 1) >= SL && stall_h < 0) stall_h = h;
`endif
                if (!(m_passed[h] || (hit && d == 1))) all = 0;
            end
            if (fail_h >= 0) begin
                m_fail = 1; m_code = fcode; m_hart = fail_h; m_done = 1;
            end else if (stall_h >= 0) begin
                m_stall = 1; m_hart = stall_h; m_done = 1;
            end else if (all) begin
                m_pass = 1; m_done = 1;
            end else if (m_t == TO - 1) begin
                m_timeout = 1; m_done = 1;
            end
            for (int h = 0; h < NH; h++) begin
                if (retire_valid[h]) m_last[h] = m_t;
                if (st_valid[h] && st_addr[h*AW +: AW] == TOHOST && st_data[h*DW +: DW] == 1)
                    m_passed[h] = 1;
            end
            m_t++;
        end
    endtask

    task automatic check_all();
        chk("core_reset",  {31'b0, core_reset}, {31'b0, !(m_run && !m_done)});
        chk("done",        {31'b0, done},       {31'b0, m_done});
        chk("pass",        {31'b0, pass},       {31'b0, m_pass});
        chk("fail",        {31'b0, fail},       {31'b0, m_fail});
        chk("timeout",     {31'b0, timeout},    {31'b0, m_timeout});
        chk("stall",       {31'b0, stall},      {31'b0, m_stall});
        chk("fail_code",   fail_code,           m_code);
        chk("fail_hart",   {31'b0, fail_hart},  m_hart);
        chk("cycle_count", cycle_count,         m_t);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic clr_in();
        retire_valid = '0; st_valid = '0; st_addr = '0; st_data = '0;
    endtask

    task automatic do_reset(input int n);
        clr_in();
        reset = 1'b1;
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd2;
            3: return 32'd3;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_until_done(input int retire_stop, input bit rnd, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            clr_in();
            if (m_run) begin
                retire_valid = (m_t < retire_stop) ? '1 : '0;
                if (rnd) retire_valid = NH'($urandom);
                foreach (sched[i]) begin
                    if (sched[i].t == m_t) begin
                        st_valid[sched[i].h]            = 1'b1;
                        st_addr[sched[i].h*AW +: AW]    = sched[i].a;
                        st_data[sched[i].h*DW +: DW]    = sched[i].d;
                    end
                end
                if (rnd) begin
                    for (int h = 0; h < NH; h++) begin
                        if ($urandom_range(0, 7) == 0) begin
                            st_valid[h]         = 1'b1;
                            st_addr[h*AW +: AW] = $urandom_range(0, 2) != 0 ? TOHOST : $urandom;
                            st_data[h*DW +: DW] = rnd_data();
                        end
                    end
                end
            end
            cyc();
            n++;
        end
        chk("budget_done", {31'b0, done}, 32'd1);
        sched.delete();
        clr_in();
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        @(negedge clk);
        do_reset(2);
        chk("reset_core_reset", {31'b0, core_reset}, 32'd1);
        chk("reset_cycle_count", cycle_count, 32'd0);

        // two harts pass at different cycles; pass only once both have
        sched.push_back('{5, 1, TOHOST, 32'd1});
        sched.push_back('{9, 0, TOHOST, 32'd1});
        run_until_done(1000, 0, 80);
        chk("t_pass", {31'b0, pass}, 32'd1);
        chk("t_pass_cc", cycle_count, 32'd10);

        // console write ignored, off-address store ignored, odd value fails
        do_reset(1);
        sched.push_back('{2, 0, 32'h0000_2000, 32'd1});
        sched.push_back('{3, 0, TOHOST, 32'h2A});
        sched.push_back('{6, 0, TOHOST, 32'h2B});
        run_until_done(1000, 0, 80);
        chk("t_fail", {31'b0, fail}, 32'd1);
        chk("t_fail_code", fail_code, 32'h15);
        chk("t_fail_hart", {31'b0, fail_hart}, 32'd0);
        chk("t_fail_cc", cycle_count, 32'd7);

        // same-cycle pass on hart0 and fail on hart1
        do_reset(1);
        sched.push_back('{4, 0, TOHOST, 32'd1});
        sched.push_back('{4, 1, TOHOST, 32'd7});
        run_until_done(1000, 0, 80);
        chk("t_same_fail", {31'b0, fail}, 32'd1);
        chk("t_same_hart", {31'b0, fail_hart}, 32'd1);
        chk("t_same_code", fail_code, 32'd3);

        // continuous retire, nothing written: timeout
        do_reset(1);
        run_until_done(1000, 0, 80);
        chk("t_timeout", {31'b0, timeout}, 32'd1);
        chk("t_timeout_cc", cycle_count, TO);
        chk("t_timeout_core_reset", {31'b0, core_reset}, 32'd1);

        // retire stops at cycle 20
        do_reset(1);
        run_until_done(20, 0, 80);
`ifdef TEST_MON_STALL_DETECT_EN
        chk("t_stall", {31'b0, stall}, 32'd1);
        chk("t_stall_hart", {31'b0, fail_hart}, 32'd0);
`else
        chk("t_nostall_timeout", {31'b0, timeout}, 32'd1);
`endif

        // outputs stay frozen in DONE whatever the inputs do
        repeat (4) begin
            retire_valid = NH'($urandom);
            st_valid = '1;
            st_addr = {TOHOST, TOHOST};
            st_data = {32'd3, 32'd5};
            cyc();
        end
        clr_in();

        // reset pulsed mid-run, then a clean rerun
        do_reset(1);
        for (int i = 0; i < RC + 12; i++) begin
            retire_valid = '1;
            cyc();
        end
        do_reset(1);
        chk("t_midreset_cc", cycle_count, 32'd0);
        chk("t_midreset_core_reset", {31'b0, core_reset}, 32'd1);
        sched.push_back('{2, 0, TOHOST, 32'd1});
        sched.push_back('{2, 1, TOHOST, 32'd1});
        run_until_done(1000, 0, 80);
        chk("t_rerun_pass", {31'b0, pass}, 32'd1);
        chk("t_rerun_cc", cycle_count, 32'd3);

        // random traffic against the model
        for (int r = 0; r < 25; r++) begin
            do_reset(1);
            run_until_done(1000, 1, 80);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
